// File: rtl/dispatch_buffer.sv
// dispatch_buffer
//   Registered dispatch stage between decode/rename and the issue queues
//   (INT, LW/SW, MULT, DIV). Each accepted instruction is classified and
//   turned into a reservation packet. The packet is held in an in-order
//   DEPTH-entry circular buffer. While a packet waits, its missing operands
//   snoop NUM_CDB common-data-bus channels. The head packet is offered to
//   exactly one issue queue through a one-hot valid/ready handshake.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous kill of every buffered entry
//   in_valid / in_ready    decode-side handshake (in_ready = count < DEPTH)
//   rs*_decoded, rs*_data, rs*_sel_cdb_or_regfile, rs*_valid_plus_tag,
//   rd_tag, opcode, func3, func7, imm
//                          decoded instruction and renamed operands
//   cdb_valid/tag/data     packed CDB broadcasts, channel c at [c*W +: W]
//   out_valid / out_ready  one-hot head target {DIV, MULT, LS, INT}
//   out_*                  head packet fields (operands CDB-bypassed);
//                          all fields read as zero while the buffer is empty
module dispatch_buffer #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int DEPTH   = 2,
  parameter int NUM_CDB = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                rs1_decoded,
  input  logic [4:0]                rs2_decoded,
  input  logic [DATA_W-1:0]         rs1_data,
  input  logic [DATA_W-1:0]         rs2_data,
  input  logic                      rs1_sel_cdb_or_regfile,
  input  logic                      rs2_sel_cdb_or_regfile,
  input  logic [TAG_W:0]            rs1_valid_plus_tag,
  input  logic [TAG_W:0]            rs2_valid_plus_tag,
  input  logic [TAG_W-1:0]          rd_tag,
  input  logic [6:0]                opcode,
  input  logic [2:0]                func3,
  input  logic [6:0]                func7,
  input  logic [DATA_W-1:0]         imm,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic [3:0]                out_valid,
  input  logic [3:0]                out_ready,
  output logic [DATA_W-1:0]         out_rs1_data,
  output logic [DATA_W-1:0]         out_rs2_data,
  output logic                      out_rs1_valid,
  output logic                      out_rs2_valid,
  output logic [TAG_W-1:0]          out_rs1_tag,
  output logic [TAG_W-1:0]          out_rs2_tag,
  output logic [TAG_W-1:0]          out_rd_tag,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_func3,
  output logic [6:0]                out_func7,
  output logic [DATA_W-1:0]         out_imm,
  output logic                      out_is_store
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Encoding equals the out_valid bit index of the target queue.
  typedef enum logic [1:0] {
    CLS_INT  = 2'd0,
    CLS_LS   = 2'd1,
    CLS_MULT = 2'd2,
    CLS_DIV  = 2'd3
  } cls_e;

  // Returns {hit, data}. Channels are scanned high to low so the lowest
  // matching channel is the last writer and wins.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  t,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && (t[c*TAG_W +: TAG_W] == tag)) r = {1'b1, d[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // Control state
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Packet storage (not reset; qualified by vld_q / count_q)
  cls_e              cls_q      [DEPTH];
  cls_e              cls_d      [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [DATA_W-1:0] rs1_data_d [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];
  logic [DATA_W-1:0] rs2_data_d [DEPTH];
  logic [DEPTH-1:0]  rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_d  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_d  [DEPTH];
  logic [TAG_W-1:0]  rd_tag_q   [DEPTH];
  logic [TAG_W-1:0]  rd_tag_d   [DEPTH];
  logic [6:0]        opcode_q   [DEPTH];
  logic [6:0]        opcode_d   [DEPTH];
  logic [2:0]        func3_q    [DEPTH];
  logic [2:0]        func3_d    [DEPTH];
  logic [6:0]        func7_q    [DEPTH];
  logic [6:0]        func7_d    [DEPTH];
  logic [DATA_W-1:0] imm_q      [DEPTH];
  logic [DATA_W-1:0] imm_d      [DEPTH];

  // Incoming classification
  logic keep, rs2_is_imm, rs2_force;
  cls_e in_cls;

  always_comb begin
    keep       = 1'b1;
    in_cls     = CLS_INT;
    rs2_is_imm = 1'b0;
    rs2_force  = 1'b0;
    case (opcode)
      OP_R: begin
        if (func7 == 7'd1 && func3 == 3'd4)      in_cls = CLS_DIV;
        else if (func7 == 7'd1 && func3 == 3'd0) in_cls = CLS_MULT;
      end
      OP_I, OP_LUI:           rs2_is_imm = 1'b1;
      OP_LW: begin
        in_cls    = CLS_LS;
        rs2_force = 1'b1;
      end
      OP_S:                   in_cls = CLS_LS;
      OP_JALR, OP_B, OP_AUIPC: in_cls = CLS_INT;
      default:                keep = 1'b0;
    endcase
  end

  // Incoming operands: class overrides first, then the same-cycle snoop
  // only for operands still outstanding.
  logic              in_rs1_base, in_rs2_base;
  logic [DATA_W:0]   in_rs1_snp, in_rs2_snp;
  logic              in_rs1_rdy, in_rs2_rdy;
  logic [DATA_W-1:0] in_rs1_val, in_rs2_val, in_rs2_src;

  assign in_rs1_base = (rs1_decoded == 5'd0) | rs1_sel_cdb_or_regfile
                     | ~rs1_valid_plus_tag[TAG_W];
  assign in_rs2_base = (rs2_decoded == 5'd0) | rs2_sel_cdb_or_regfile
                     | ~rs2_valid_plus_tag[TAG_W] | rs2_is_imm | rs2_force;
  assign in_rs1_snp  = cdb_match(rs1_valid_plus_tag[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
  assign in_rs2_snp  = cdb_match(rs2_valid_plus_tag[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
  assign in_rs1_rdy  = in_rs1_base | in_rs1_snp[DATA_W];
  assign in_rs2_rdy  = in_rs2_base | in_rs2_snp[DATA_W];
  assign in_rs2_src  = rs2_is_imm ? imm : rs2_data;
  assign in_rs1_val  = (!in_rs1_base && in_rs1_snp[DATA_W]) ? in_rs1_snp[DATA_W-1:0] : rs1_data;
  assign in_rs2_val  = (!in_rs2_base && in_rs2_snp[DATA_W]) ? in_rs2_snp[DATA_W-1:0] : in_rs2_src;

  // Per-entry snoop results, shared by resident capture and head bypass
  logic [DATA_W:0] rs1_snp [DEPTH];
  logic [DATA_W:0] rs2_snp [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    assign rs1_snp[i] = cdb_match(rs1_tag_q[i], cdb_valid, cdb_tag, cdb_data);
    assign rs2_snp[i] = cdb_match(rs2_tag_q[i], cdb_valid, cdb_tag, cdb_data);
  end

  // Handshakes. A flush discards both the enqueue and the dequeue.
  logic nonempty, enq, wr_en, deq;

  assign nonempty = (count_q != '0);
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign enq      = in_valid & in_ready & ~flush;
  assign wr_en    = enq & keep;
  assign deq      = (|(out_valid & out_ready)) & ~flush;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    vld_d    = vld_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      vld_d    = '0;
    end else begin
      if (wr_en) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq);
    end
  end

  always_comb begin
    cls_d      = cls_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_rdy_d  = rs1_rdy_q;
    rs2_rdy_d  = rs2_rdy_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_tag_d  = rs2_tag_q;
    rd_tag_d   = rd_tag_q;
    opcode_d   = opcode_q;
    func3_d    = func3_q;
    func7_d    = func7_q;
    imm_d      = imm_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !rs1_rdy_q[i] && rs1_snp[i][DATA_W]) begin
        rs1_rdy_d[i]  = 1'b1;
        rs1_data_d[i] = rs1_snp[i][DATA_W-1:0];
      end
      if (vld_q[i] && !rs2_rdy_q[i] && rs2_snp[i][DATA_W]) begin
        rs2_rdy_d[i]  = 1'b1;
        rs2_data_d[i] = rs2_snp[i][DATA_W-1:0];
      end
    end
    // The write slot is never occupied, so it cannot collide with a capture.
    if (wr_en) begin
      cls_d[wr_ptr_q]      = in_cls;
      rs1_data_d[wr_ptr_q] = in_rs1_val;
      rs2_data_d[wr_ptr_q] = in_rs2_val;
      rs1_rdy_d[wr_ptr_q]  = in_rs1_rdy;
      rs2_rdy_d[wr_ptr_q]  = in_rs2_rdy;
      rs1_tag_d[wr_ptr_q]  = rs1_valid_plus_tag[TAG_W-1:0];
      rs2_tag_d[wr_ptr_q]  = rs2_valid_plus_tag[TAG_W-1:0];
      rd_tag_d[wr_ptr_q]   = rd_tag;
      opcode_d[wr_ptr_q]   = opcode;
      func3_d[wr_ptr_q]    = func3;
      func7_d[wr_ptr_q]    = func7;
      imm_d[wr_ptr_q]      = imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    cls_q      <= cls_d;
    rs1_data_q <= rs1_data_d;
    rs2_data_q <= rs2_data_d;
    rs1_rdy_q  <= rs1_rdy_d;
    rs2_rdy_q  <= rs2_rdy_d;
    rs1_tag_q  <= rs1_tag_d;
    rs2_tag_q  <= rs2_tag_d;
    rd_tag_q   <= rd_tag_d;
    opcode_q   <= opcode_d;
    func3_q    <= func3_d;
    func7_q    <= func7_d;
    imm_q      <= imm_d;
  end

  // Head presentation with same-cycle CDB bypass; zero while empty.
  always_comb begin
    out_valid     = '0;
    out_rs1_data  = '0;
    out_rs2_data  = '0;
    out_rs1_valid = 1'b0;
    out_rs2_valid = 1'b0;
    out_rs1_tag   = '0;
    out_rs2_tag   = '0;
    out_rd_tag    = '0;
    out_opcode    = '0;
    out_func3     = '0;
    out_func7     = '0;
    out_imm       = '0;
    out_is_store  = 1'b0;
    if (nonempty) begin
      out_valid     = 4'b0001 << cls_q[rd_ptr_q];
      out_rs1_valid = rs1_rdy_q[rd_ptr_q] | rs1_snp[rd_ptr_q][DATA_W];
      out_rs2_valid = rs2_rdy_q[rd_ptr_q] | rs2_snp[rd_ptr_q][DATA_W];
      out_rs1_data  = (!rs1_rdy_q[rd_ptr_q] && rs1_snp[rd_ptr_q][DATA_W])
                    ? rs1_snp[rd_ptr_q][DATA_W-1:0] : rs1_data_q[rd_ptr_q];
      out_rs2_data  = (!rs2_rdy_q[rd_ptr_q] && rs2_snp[rd_ptr_q][DATA_W])
                    ? rs2_snp[rd_ptr_q][DATA_W-1:0] : rs2_data_q[rd_ptr_q];
      out_rs1_tag   = rs1_tag_q[rd_ptr_q];
      out_rs2_tag   = rs2_tag_q[rd_ptr_q];
      out_rd_tag    = rd_tag_q[rd_ptr_q];
      out_opcode    = opcode_q[rd_ptr_q];
      out_func3     = func3_q[rd_ptr_q];
      out_func7     = func7_q[rd_ptr_q];
      out_imm       = imm_q[rd_ptr_q];
      out_is_store  = (opcode_q[rd_ptr_q] != OP_LW);
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
module tb_dispatch_buffer;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 6;
  localparam int DEPTH   = 2;
  localparam int NUM_CDB = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      flush, in_valid, in_ready;
  logic [4:0]                rs1_decoded, rs2_decoded;
  logic [DATA_W-1:0]         rs1_data, rs2_data, imm;
  logic                      rs1_sel_cdb_or_regfile, rs2_sel_cdb_or_regfile;
  logic [TAG_W:0]            rs1_valid_plus_tag, rs2_valid_plus_tag;
  logic [TAG_W-1:0]          rd_tag;
  logic [6:0]                opcode, func7;
  logic [2:0]                func3;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [3:0]                out_valid, out_ready;
  logic [DATA_W-1:0]         out_rs1_data, out_rs2_data, out_imm;
  logic                      out_rs1_valid, out_rs2_valid, out_is_store;
  logic [TAG_W-1:0]          out_rs1_tag, out_rs2_tag, out_rd_tag;
  logic [6:0]                out_opcode, out_func7;
  logic [2:0]                out_func3;

  always #5 clk = ~clk;

  dispatch_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_decoded(rs1_decoded), .rs2_decoded(rs2_decoded),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_sel_cdb_or_regfile(rs1_sel_cdb_or_regfile), .rs2_sel_cdb_or_regfile(rs2_sel_cdb_or_regfile),
    .rs1_valid_plus_tag(rs1_valid_plus_tag), .rs2_valid_plus_tag(rs2_valid_plus_tag),
    .rd_tag(rd_tag), .opcode(opcode), .func3(func3), .func7(func7), .imm(imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid),
    .out_rs1_tag(out_rs1_tag), .out_rs2_tag(out_rs2_tag), .out_rd_tag(out_rd_tag),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_imm(out_imm), .out_is_store(out_is_store)
  );

  typedef struct {
    logic [3:0]        oh;
    logic              r1v;
    logic [DATA_W-1:0] r1d;
    logic [TAG_W-1:0]  r1t;
    logic              r2v;
    logic [DATA_W-1:0] r2d;
    logic [TAG_W-1:0]  r2t;
    logic [TAG_W-1:0]  rd;
    logic [6:0]        op;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [DATA_W-1:0] im;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {kept, one-hot target} straight from the opcode table.
  function automatic logic [4:0] classify(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    case (op)
      7'h33:   return (f7 == 7'd1 && f3 == 3'd4) ? 5'b1_1000 :
                      (f7 == 7'd1 && f3 == 3'd0) ? 5'b1_0100 : 5'b1_0001;
      7'h13, 7'h37, 7'h67, 7'h63, 7'h17: return 5'b1_0001;
      7'h03, 7'h23: return 5'b1_0010;
      default: return 5'b0_0000;
    endcase
  endfunction

  task automatic cdb_lookup(input logic [TAG_W-1:0] t, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!hit && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
        hit = 1'b1;
        d   = cdb_data[c*DATA_W +: DATA_W];
      end
    end
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    rs1_decoded = 0; rs2_decoded = 0; rs1_data = '0; rs2_data = '0; imm = '0;
    rs1_sel_cdb_or_regfile = 0; rs2_sel_cdb_or_regfile = 0;
    rs1_valid_plus_tag = '0; rs2_valid_plus_tag = '0; rd_tag = '0;
    opcode = 7'h00; func3 = 3'd0; func7 = 7'd0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [TAG_W-1:0] rd, input logic [DATA_W-1:0] im);
    in_valid = 1; opcode = op; func3 = f3; func7 = f7; rd_tag = rd; imm = im;
    rs1_decoded = 0; rs2_decoded = 0; rs1_data = 32'h11; rs2_data = 32'h22;
    rs1_valid_plus_tag = '0; rs2_valid_plus_tag = '0;
  endtask

  // Compare the DUT with the model for the current inputs, then advance
  // the model across one rising edge. Called with inputs set after a
  // falling edge; returns at the next falling edge.
  task automatic step();
    ent_t h, e;
    logic hit, bv, deq, enq;
    logic [DATA_W-1:0] hd, bd;
    logic [4:0] k;
    #1;
    chk("in_ready", in_ready, mq.size() < DEPTH);
    if (mq.size() == 0) begin
      chk("out_valid_empty", out_valid, 4'b0000);
      chk("rs1_data_empty", out_rs1_data, '0);
      chk("rs2_data_empty", out_rs2_data, '0);
      chk("imm_empty", out_imm, '0);
      chk("opcode_empty", out_opcode, '0);
      chk("rd_tag_empty", out_rd_tag, '0);
      chk("is_store_empty", out_is_store, 1'b0);
    end else begin
      h = mq[0];
      chk("out_valid", out_valid, h.oh);
      bv = h.r1v; bd = h.r1d;
      if (!bv) begin cdb_lookup(h.r1t, hit, hd); if (hit) begin bv = 1; bd = hd; end end
      chk("rs1_valid", out_rs1_valid, bv);
      if (bv) chk("rs1_data", out_rs1_data, bd);
      bv = h.r2v; bd = h.r2d;
      if (!bv) begin cdb_lookup(h.r2t, hit, hd); if (hit) begin bv = 1; bd = hd; end end
      chk("rs2_valid", out_rs2_valid, bv);
      if (bv) chk("rs2_data", out_rs2_data, bd);
      chk("rs1_tag", out_rs1_tag, h.r1t);
      chk("rs2_tag", out_rs2_tag, h.r2t);
      chk("rd_tag", out_rd_tag, h.rd);
      chk("opcode", out_opcode, h.op);
      chk("func3", out_func3, h.f3);
      chk("func7", out_func7, h.f7);
      chk("imm", out_imm, h.im);
      chk("is_store", out_is_store, h.op != 7'h03);
    end
    deq = (mq.size() > 0) && ((mq[0].oh & out_ready) != 4'b0) && !flush;
    enq = in_valid && (mq.size() < DEPTH) && !flush;
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (!e.r1v) begin cdb_lookup(e.r1t, hit, hd); if (hit) begin e.r1v = 1; e.r1d = hd; end end
      if (!e.r2v) begin cdb_lookup(e.r2t, hit, hd); if (hit) begin e.r2v = 1; e.r2d = hd; end end
      mq[i] = e;
    end
    if (flush) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      k = classify(opcode, func3, func7);
      if (enq && k[4]) begin
        e.oh = k[3:0]; e.op = opcode; e.f3 = func3; e.f7 = func7; e.im = imm; e.rd = rd_tag;
        e.r1t = rs1_valid_plus_tag[TAG_W-1:0];
        e.r2t = rs2_valid_plus_tag[TAG_W-1:0];
        e.r1v = (rs1_decoded == 0) || rs1_sel_cdb_or_regfile || !rs1_valid_plus_tag[TAG_W];
        e.r2v = (rs2_decoded == 0) || rs2_sel_cdb_or_regfile || !rs2_valid_plus_tag[TAG_W];
        e.r1d = rs1_data;
        e.r2d = rs2_data;
        if (opcode == 7'h13 || opcode == 7'h37) begin e.r2v = 1; e.r2d = imm; end
        if (opcode == 7'h03) e.r2v = 1;
        if (!e.r1v) begin cdb_lookup(e.r1t, hit, hd); if (hit) begin e.r1v = 1; e.r1d = hd; end end
        if (!e.r2v) begin cdb_lookup(e.r2t, hit, hd); if (hit) begin e.r2v = 1; e.r2d = hd; end end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [12];
    ops = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h67, 7'h63, 7'h17, 7'h6F, 7'h7F};
    in_valid = ($urandom_range(0, 3) != 0);
    opcode   = ops[$urandom_range(0, 11)];
    func7    = ($urandom_range(0, 2) != 0) ? 7'd1 : 7'($urandom);
    func3    = 3'($urandom);
    imm      = $urandom;
    rd_tag   = TAG_W'($urandom);
    rs1_decoded = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rs2_decoded = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rs1_data = $urandom;
    rs2_data = $urandom;
    rs1_sel_cdb_or_regfile = ($urandom_range(0, 3) == 0);
    rs2_sel_cdb_or_regfile = ($urandom_range(0, 3) == 0);
    rs1_valid_plus_tag = {1'($urandom), TAG_W'($urandom_range(0, 7))};
    rs2_valid_plus_tag = {1'($urandom), TAG_W'($urandom_range(0, 7))};
    cdb_valid = NUM_CDB'($urandom);
    for (int c = 0; c < NUM_CDB; c++) begin
      cdb_tag[c*TAG_W +: TAG_W]   = TAG_W'($urandom_range(0, 7));
      cdb_data[c*DATA_W +: DATA_W] = $urandom;
    end
    out_ready = 4'($urandom);
    flush     = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    idle();
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();                                            // reset state

    // ADDI rs1=x0, imm=5
    set_instr(7'h13, 3'd0, 7'd0, 6'd1, 32'h5);
    step();
    idle();
    #1;
    chk("addi_out_valid", out_valid, 4'b0001);
    chk("addi_rs2_data", out_rs2_data, 32'h5);
    chk("addi_rs1_valid", out_rs1_valid, 1'b1);
    chk("addi_rs2_valid", out_rs2_valid, 1'b1);
    out_ready = 4'b1111;
    step();

    // MUL then DIV, every queue ready
    set_instr(7'h33, 3'd0, 7'd1, 6'd2, '0);
    step();
    set_instr(7'h33, 3'd4, 7'd1, 6'd3, '0);
    #1 chk("mul_out_valid", out_valid, 4'b0100);
    step();
    idle();
    #1 chk("div_out_valid", out_valid, 4'b1000);
    step();

    // ADD with busy rs1 tag 0x0A, woken on CDB channel 1 two cycles later
    out_ready = 4'b0000;
    set_instr(7'h33, 3'd0, 7'd0, 6'd4, '0);
    rs1_decoded = 5'd3;
    rs1_valid_plus_tag = {1'b1, 6'h0A};
    step();
    idle();
    step();
    step();
    cdb_valid = 2'b10;
    cdb_tag   = {6'h0A, 6'h01};
    cdb_data  = {32'hDEADBEEF, 32'h12345678};
    #1;
    chk("wake_rs1_valid", out_rs1_valid, 1'b1);
    chk("wake_rs1_data", out_rs1_data, 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("held_rs1_valid", out_rs1_valid, 1'b1);
    chk("held_rs1_data", out_rs1_data, 32'hDEADBEEF);
    out_ready = 4'b0001;
    step();

    // Three back-to-back ADDs into a two-entry buffer
    out_ready = 4'b0000;
    set_instr(7'h33, 3'd0, 7'd0, 6'd11, '0); step();
    set_instr(7'h33, 3'd0, 7'd0, 6'd12, '0); step();
    set_instr(7'h33, 3'd0, 7'd0, 6'd13, '0);
    #1 chk("full_in_ready", in_ready, 1'b0);
    step();
    out_ready = 4'b0001;
    #1 chk("fifo_first", out_rd_tag, 6'd11);
    chk("full_deq_in_ready", in_ready, 1'b0);
    step();
    #1 chk("fifo_second", out_rd_tag, 6'd12);
    step();
    idle();
    #1 chk("fifo_third", out_rd_tag, 6'd13);
    step();

    // JAL dropped, SW delivered to LS
    out_ready = 4'b0000;
    set_instr(7'h6F, 3'd0, 7'd0, 6'd20, '0); step();
    set_instr(7'h23, 3'd2, 7'd0, 6'd21, 32'h8);
    #1 chk("jal_no_valid", out_valid, 4'b0000);
    step();
    idle();
    #1;
    chk("sw_out_valid", out_valid, 4'b0010);
    chk("sw_is_store", out_is_store, 1'b1);
    chk("sw_rd_tag", out_rd_tag, 6'd21);
    out_ready = 4'b0010;
    step();

    // Flush a full buffer with an instruction presented
    out_ready = 4'b0000;
    set_instr(7'h33, 3'd0, 7'd0, 6'd30, '0); step();
    set_instr(7'h33, 3'd0, 7'd0, 6'd31, '0); step();
    set_instr(7'h33, 3'd0, 7'd0, 6'd32, '0);
    flush = 1;
    step();
    idle();
    #1;
    chk("flush_out_valid", out_valid, 4'b0000);
    chk("flush_in_ready", in_ready, 1'b1);
    step();
    step();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of traffic
    idle();
    out_ready = 4'b0000;
    set_instr(7'h13, 3'd0, 7'd0, 6'd40, 32'h9); step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 4'b0000);
    chk("arst_in_ready", in_ready, 1'b1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
- Registered, parametrised dispatch stage between decode/rename and the issue queues (INT, LW/SW, MULT, DIV).
- Classifies each decoded instruction, builds the reservation packet and holds it in an in-order DEPTH-entry buffer.
- Each buffered entry snoops NUM_CDB common-data-bus channels so that operand wakeups are not lost while the packet waits.
- Presents the head packet to exactly one queue through a per-queue valid/ready handshake; supports pipeline flush.

Parameters:
- DATA_W, 32, operand, immediate and CDB data width.
- TAG_W, 6, ROB/rename tag width; the rsX_valid_plus_tag inputs are TAG_W+1 bits wide.
- DEPTH, 2, number of buffer entries; power of two, at least 2.
- NUM_CDB, 2, number of CDB broadcast channels snooped.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  buffer can accept an instruction: count<DEPTH.
- rs1_decoded, rs2_decoded  in  5  architectural source indexes.
- rs1_data, rs2_data  in  DATA_W  register-file or CDB operand values.
- rs1_sel_cdb_or_regfile, rs2_sel_cdb_or_regfile  in  1  1 = supplied data is already final.
- rs1_valid_plus_tag, rs2_valid_plus_tag  in  TAG_W+1  MSB = busy, low bits = producer tag.
- rd_tag  in  TAG_W  destination tag.
- opcode  in  7  instruction opcode.
- func3  in  3  instruction func3.
- func7  in  7  instruction func7.
- imm  in  DATA_W  immediate.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  packed broadcast tags; channel c occupies bits [c*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  packed broadcast data, same packing.
- out_valid  out  4  one-hot head-target valid: bit0 INT, bit1 LS, bit2 MULT, bit3 DIV.
- out_ready  in  4  per-queue accept, same bit order.
- out_rs1_data, out_rs2_data  out  DATA_W  head operand data, CDB-bypassed.
- out_rs1_valid, out_rs2_valid  out  1  head operand ready flags, CDB-bypassed.
- out_rs1_tag, out_rs2_tag, out_rd_tag  out  TAG_W  head tags.
- out_opcode  out  7  head opcode.
- out_func3  out  3  head func3.
- out_func7  out  7  head func7.
- out_imm  out  DATA_W  head immediate.
- out_is_store  out  1  0 for LW (0000011), 1 otherwise.

Behaviour:
- Reset:
  - count, rd_ptr and wr_ptr = 0.
  - All entry valid bits = 0; out_valid = 0; in_ready = 1.
  - Every out_* data field = 0 while the buffer is empty.
- Enqueue condition: in_valid && in_ready && !flush.
- Class decode at enqueue:
  - R_TYPE 0110011, func7=1, func3=4: DIV.
  - R_TYPE 0110011, func7=1, func3=0: MULT.
  - R_TYPE 0110011, any other func3/func7: INT.
  - I_TYPE 0010011 and LUI 0110111: INT; rs2_data := imm and rs2_valid := 1.
  - LW 0000011: LS; rs2_valid := 1.
  - S_TYPE 0100011: LS.
  - JALR 1100111, B_TYPE 1100011, AUIPC 0010111: INT.
  - J_TYPE 1101111 and unknown opcodes: the handshake completes but no entry is written (dropped).
- Operand valid at enqueue, per source: 1 when rsX_decoded==0, else 1 when sel_cdb_or_regfile=1, else ~busy.
- Enqueue-cycle snoop:
  - If an incoming operand is not valid and any cdb_valid[c] has a cdb_tag[c] equal to its tag, the entry stores cdb_data[c] with valid=1.
  - If several channels match, the lowest c wins.
- Resident snoop: every cycle, each occupied entry with an invalid operand applies the same match and capture rule, registered on the next edge.
- Output bypass: the head's out_rsX_data and out_rsX_valid reflect a same-cycle CDB match combinationally, so a dequeue in the wakeup cycle carries valid=1.
- Output valid and dequeue:
  - out_valid = one-hot of the head class when count>0, else 0.
  - Dequeue when (out_valid & out_ready) != 0; rd_ptr increments and wraps modulo DEPTH.
  - Throughput is one instruction per cycle; order is strictly in-order.
  - Latency: an enqueue into an empty buffer appears on out_valid on the next cycle.
- Same-cycle enqueue and dequeue: count is unchanged; both pointers advance.
- Full: in_ready=0 when count==DEPTH, even if a dequeue occurs in that cycle (no out_ready to in_ready combinational path).
- Flush:
  - Next cycle count=0 and pointers=0.
  - Any enqueue or dequeue in the flush cycle is discarded.
  - out_valid may still be asserted during the flush cycle; queues must not accept it.
- Reset mid-operation: immediate return to reset values; buffered content is lost.

Test Plan:
- Reset, then ADDI (opcode 0x13, imm=0x5, rs1=0) -> next cycle out_valid=0001, out_rs2_data=0x5, both operand valids=1.
- MUL (func7=1, func3=0) followed by DIV (func7=1, func3=4), out_ready=1111 -> out_valid=0100, then 1000 on consecutive cycles.
- ADD with rs1 busy tag 0x0A, out_ready=0; two cycles later cdb_valid[1]=1, tag 0x0A, data 0xDEADBEEF -> same cycle out_rs1_valid=1 with data 0xDEADBEEF; value retained after the CDB drops.
- DEPTH=2, out_ready=0, three back-to-back ADDs -> in_ready=0 after the second; the third is held until a dequeue; FIFO order preserved.
- JAL (0x6F) followed by SW -> the JAL produces no out_valid; the SW yields out_valid=0010 with out_is_store=1.
- Buffer full, flush=1 together with in_valid -> next cycle out_valid=0 and in_ready=1; the flushed instruction never appears.
